// File: rtl/trap_ctrl.sv
// Machine-mode trap/return sequencer: captures exceptions and MRET at commit, owns the trap CSRs,
// flushes the pipeline and then issues one fetch redirect. Optional trap counter: TRAP_CTRL_TRAP_COUNT_EN.
module trap_ctrl #(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] MTVEC_RESET  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  output logic        commit_ready,
  input  logic [31:0] commit_pc,
  input  logic        commit_ex_valid,
  input  logic [3:0]  commit_ex,
  input  logic [31:0] commit_ex_tval,
  input  logic        commit_ret_valid,
  output logic        flush,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_target,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata
);

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MTRAPCNT = 12'h7C0;

  localparam int              CNT_W    = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;

  logic        mie_reg, mpie_reg;
  logic [31:0] mepc_reg, mcause_reg, mtval_reg, mtvec_reg, target_reg;

  logic accept, trap_take, ret_take;
  logic wr_mstatus, wr_mtvec, wr_mepc, wr_mcause, wr_mtval;
  logic unused_pc_bits;

  assign accept    = commit_valid && commit_ready;
  assign trap_take = accept && commit_ex_valid;
  assign ret_take  = accept && commit_ret_valid && !commit_ex_valid;

  assign wr_mstatus = csr_we && (csr_addr == CSR_MSTATUS);
  assign wr_mtvec   = csr_we && (csr_addr == CSR_MTVEC);
  assign wr_mepc    = csr_we && (csr_addr == CSR_MEPC);
  assign wr_mcause  = csr_we && (csr_addr == CSR_MCAUSE);
  assign wr_mtval   = csr_we && (csr_addr == CSR_MTVAL);

  // mepc is word aligned, so the low pc bits are never stored
  assign unused_pc_bits = ^commit_pc[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    commit_ready   = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    case (state_reg)
      S_IDLE: begin
        commit_ready = 1'b1;
        if (trap_take || ret_take) begin
          state_next     = S_FLUSH;
          flush_cnt_next = '0;
        end
      end
      S_FLUSH: begin
        flush = 1'b1;
        if (flush_cnt_reg == CNT_LAST) begin
          state_next     = S_REDIRECT;
          flush_cnt_next = '0;
        end else begin
          flush_cnt_next = flush_cnt_reg + CNT_W'(1);
        end
      end
      S_REDIRECT: begin
        redirect_valid = 1'b1;
        if (redirect_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next     = S_IDLE;
        flush_cnt_next = '0;
      end
    endcase
  end

  assign redirect_target = target_reg;

  // Trap/MRET updates override a same-cycle CSR write to the same register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mie_reg  <= 1'b0;
      mpie_reg <= 1'b0;
    end else if (trap_take) begin
      mpie_reg <= mie_reg;
      mie_reg  <= 1'b0;
    end else if (ret_take) begin
      mie_reg  <= mpie_reg;
      mpie_reg <= 1'b1;
    end else if (wr_mstatus) begin
      mie_reg  <= csr_wdata[3];
      mpie_reg <= csr_wdata[7];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mepc_reg   <= '0;
      mcause_reg <= '0;
      mtval_reg  <= '0;
    end else if (trap_take) begin
      mepc_reg   <= {commit_pc[31:2], 2'b00};
      mcause_reg <= {28'b0, commit_ex};
      mtval_reg  <= commit_ex_tval;
    end else begin
      if (wr_mepc) begin
        mepc_reg <= {csr_wdata[31:2], 2'b00};
      end
      if (wr_mcause) begin
        mcause_reg <= csr_wdata;
      end
      if (wr_mtval) begin
        mtval_reg <= csr_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtvec_reg <= MTVEC_RESET & 32'hFFFF_FFFC;
    end else if (wr_mtvec) begin
      mtvec_reg <= {csr_wdata[31:2], 2'b00};
    end
  end

  // Target is captured from the pre-edge CSR values and held until the next entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      target_reg <= '0;
    end else if (trap_take) begin
      target_reg <= mtvec_reg;
    end else if (ret_take) begin
      target_reg <= mepc_reg;
    end
  end

`ifdef TRAP_CTRL_TRAP_COUNT_EN
  logic [31:0] mtrapcnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtrapcnt_reg <= '0;
    end else if (trap_take) begin
      mtrapcnt_reg <= mtrapcnt_reg + 32'd1;
    end else if (csr_we && (csr_addr == CSR_MTRAPCNT)) begin
      mtrapcnt_reg <= csr_wdata;
    end
  end
`endif

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: csr_rdata = {19'b0, 2'b11, 3'b0, mpie_reg, 3'b0, mie_reg, 3'b0};
      CSR_MTVEC:   csr_rdata = mtvec_reg;
      CSR_MEPC:    csr_rdata = mepc_reg;
      CSR_MCAUSE:  csr_rdata = mcause_reg;
      CSR_MTVAL:   csr_rdata = mtval_reg;
`ifdef TRAP_CTRL_TRAP_COUNT_EN
      CSR_MTRAPCNT: csr_rdata = mtrapcnt_reg;
`endif
      default:     csr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a transaction-level model of the trap/return sequence.
module tb_trap_ctrl;
  localparam int F = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        commit_valid = 1'b0, commit_ex_valid = 1'b0, commit_ret_valid = 1'b0;
  logic [31:0] commit_pc = '0, commit_ex_tval = '0;
  logic [3:0]  commit_ex = '0;
  logic        redirect_ready = 1'b0, csr_we = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0;
  logic        commit_ready, flush, redirect_valid;
  logic [31:0] redirect_target, csr_rdata;

  always #5 clk = ~clk;

  trap_ctrl #(.FLUSH_CYCLES(F), .MTVEC_RESET(32'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_pc(commit_pc),
    .commit_ex_valid(commit_ex_valid), .commit_ex(commit_ex), .commit_ex_tval(commit_ex_tval),
    .commit_ret_valid(commit_ret_valid),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_target(redirect_target),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a sequence is "busy" from the accepting edge; m_cnt counts edges since acceptance.
  bit          m_busy, m_mie, m_mpie;
  int          m_cnt;
  logic [31:0] m_mepc, m_mcause, m_mtval, m_mtvec, m_target, m_trapcnt;
  wire         m_acc = !m_busy && commit_valid;

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h305: return m_mtvec & 32'hFFFF_FFFC;
      12'h341: return m_mepc & 32'hFFFF_FFFC;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
`ifdef TRAP_CTRL_TRAP_COUNT_EN
      12'h7C0: return m_trapcnt;
`endif
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 0; m_cnt <= 0; m_mie <= 0; m_mpie <= 0;
      m_mepc <= 0; m_mcause <= 0; m_mtval <= 0; m_target <= 0; m_trapcnt <= 0;
      m_mtvec <= 32'h8000_0000;
    end else begin
      if (m_busy) begin
        if (m_cnt > F && redirect_ready) m_busy <= 0;
        else m_cnt <= m_cnt + 1;
      end
      if (csr_we) begin
        case (csr_addr)
          12'h300: begin m_mie <= csr_wdata[3]; m_mpie <= csr_wdata[7]; end
          12'h305: m_mtvec <= csr_wdata;
          12'h341: m_mepc <= csr_wdata;
          12'h342: m_mcause <= csr_wdata;
          12'h343: m_mtval <= csr_wdata;
          12'h7C0: m_trapcnt <= csr_wdata;
          default: ;
        endcase
      end
      if (m_acc && commit_ex_valid) begin
        m_mepc <= commit_pc; m_mcause <= {28'b0, commit_ex}; m_mtval <= commit_ex_tval;
        m_mpie <= m_mie; m_mie <= 0; m_target <= m_mtvec & 32'hFFFF_FFFC;
        m_trapcnt <= m_trapcnt + 1;
        m_busy <= 1; m_cnt <= 1;
      end else if (m_acc && commit_ret_valid) begin
        m_mie <= m_mpie; m_mpie <= 1; m_target <= m_mepc & 32'hFFFF_FFFC;
        m_busy <= 1; m_cnt <= 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("commit_ready", commit_ready, m_busy ? 0 : 1);
      chk("flush", flush, (m_busy && m_cnt <= F) ? 1 : 0);
      chk("redirect_valid", redirect_valid, (m_busy && m_cnt > F) ? 1 : 0);
      chk("redirect_target", redirect_target, m_target);
      chk("csr_rdata", csr_rdata, m_read(csr_addr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1; csr_addr = a; csr_wdata = d;
    tick();
    csr_we = 0;
  endtask

  task automatic commit(input bit ex, input bit ret, input logic [31:0] pc, input logic [3:0] code);
    commit_valid = 1; commit_ex_valid = ex; commit_ret_valid = ret;
    commit_pc = pc; commit_ex = code; commit_ex_tval = pc ^ 32'hA5A5_0000;
    tick();
    commit_valid = 0; commit_ex_valid = 0; commit_ret_valid = 0;
  endtask

  task automatic rd_chk(input string nm, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    chk(nm, csr_rdata, exp);
  endtask

  initial begin
    @(posedge clk); #1; cmp_en = 1;
    tick();
    rst = 1;

    // Reset state
    @(negedge clk);
    chk("t1_commit_ready", commit_ready, 1);
    chk("t1_flush", flush, 0);
    chk("t1_redirect_valid", redirect_valid, 0);
    #1; rd_chk("t1_mtvec", 12'h305, 32'h8000_0000);
    tick();

    // Trap entry with MIE set
    csr_wr(12'h300, 32'h8);
    commit(1, 0, 32'h100, 4'd11);
    @(negedge clk); chk("t2_flush_c1", flush, 1); chk("t2_rv_c1", redirect_valid, 0);
    tick();
    @(negedge clk); chk("t2_flush_c2", flush, 1);
    tick();
    @(negedge clk);
    chk("t2_flush_c3", flush, 0);
    chk("t2_rv_c3", redirect_valid, 1);
    chk("t2_target", redirect_target, 32'h8000_0000);
    #1; rd_chk("t2_mepc", 12'h341, 32'h100);
    rd_chk("t2_mcause", 12'h342, 32'd11);
    rd_chk("t2_mstatus", 12'h300, 32'h1880);
    redirect_ready = 1;
    tick();
    redirect_ready = 0;

    // MRET with redirect back-pressure
    commit(0, 1, 32'h104, 4'd0);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_rv_hold", redirect_valid, 1);
      chk("t4_target_hold", redirect_target, 32'h100);
      chk("t4_commit_ready", commit_ready, 0);
      tick();
    end
    redirect_ready = 1;
    tick();
    redirect_ready = 0;
    @(negedge clk); chk("t4_idle", commit_ready, 1);
    #1; rd_chk("t3_mstatus", 12'h300, 32'h1888);
    tick();

    // mtvec alignment; trap beats a same-cycle mepc write
    csr_wr(12'h305, 32'h1003);
    @(negedge clk); #1; rd_chk("t5_mtvec", 12'h305, 32'h1000);
    tick();
    csr_we = 1; csr_addr = 12'h341; csr_wdata = 32'h55;
    commit(1, 0, 32'h200, 4'd2);
    csr_we = 0;
    redirect_ready = 1;
    tick();
    @(negedge clk); chk("t5_target", redirect_target, 32'h1000);
    tick(); tick();
    redirect_ready = 0;
    @(negedge clk); #1; rd_chk("t5_mepc", 12'h341, 32'h200);
    tick();

`ifdef TRAP_CTRL_TRAP_COUNT_EN
    csr_wr(12'h7C0, 32'hFFFF_FFFF);
    commit(1, 0, 32'h300, 4'd3);
    redirect_ready = 1;
    repeat (3) tick();
    redirect_ready = 0;
    @(negedge clk); #1; rd_chk("t6_trapcnt_wrap", 12'h7C0, 32'h0);
    tick();
`endif

    // Asynchronous reset during FLUSH
    csr_addr = 12'h305;
    commit(1, 0, 32'h400, 4'd5);
    @(negedge clk); chk("t6_flush_pre", flush, 1);
    #1; rst = 0;
    #1;
    chk("t6_flush_rst", flush, 0);
    chk("t6_rv_rst", redirect_valid, 0);
    chk("t6_target_rst", redirect_target, 0);
    chk("t6_mtvec_rst", csr_rdata, 32'h8000_0000);
    tick();
    rst = 1;
    tick();
    @(negedge clk); chk("t6_idle", commit_ready, 1);
    tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      commit_valid     = ($urandom_range(0, 1) == 1);
      commit_ex_valid  = ($urandom_range(0, 2) == 0);
      commit_ret_valid = ($urandom_range(0, 2) == 0);
      commit_pc        = $urandom;
      commit_ex        = 4'($urandom);
      commit_ex_tval   = $urandom;
      redirect_ready   = ($urandom_range(0, 1) == 1);
      csr_we           = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 6))
        0: csr_addr = 12'h300;
        1: csr_addr = 12'h305;
        2: csr_addr = 12'h341;
        3: csr_addr = 12'h342;
        4: csr_addr = 12'h343;
        5: csr_addr = 12'h7C0;
        default: csr_addr = 12'h123;
      endcase
      csr_wdata = $urandom;
      rst = ($urandom_range(0, 299) != 0);
      tick();
    end

    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
